// File: rtl/stage_wb_mt_pkg.sv
// Shared types and constants for the multithreaded writeback/commit stage.
package stage_wb_mt_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned VPN_W_DEF = 20;
  localparam int unsigned PPN_W_DEF = 8;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned TID_W_DEF = 2;

  typedef logic [TID_W_DEF-1:0] threadid_t;
  typedef logic [REG_W-1:0]     regid_t;
  typedef logic [XLEN_DEF-1:0]  word_t;
  typedef logic [XLEN_DEF-1:0]  vptr_t;
  typedef logic [VPN_W_DEF-1:0] vpn_t;
  typedef logic [PPN_W_DEF-1:0] ppn_t;

  typedef enum logic [1:0] {
    TLBW_NONE = 2'd0,
    TLBW_ITLB = 2'd1,
    TLBW_DTLB = 2'd2
  } tlbwrite_t;

  // Cause codes written to rm2 on entry to the handler.
  localparam int unsigned EXC_ITLB = 1;
  localparam int unsigned EXC_DTLB = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HANDLER = 2'd1,
    RELEASE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/stage_wb_mt_if.sv
// TL-to-writeback bus plus the commit-side outputs of the writeback stage.
interface stage_wb_mt_if #(
  parameter int unsigned N_THREADS = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned VPN_W     = 20,
  parameter int unsigned PPN_W     = 8
) ();
  import stage_wb_mt_pkg::*;

  localparam int unsigned T_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  logic [T_W-1:0]  tl_thread;
  logic            tl_isvalid;
  logic            tl_itlb_miss;
  logic            tl_dtlb_miss;
  regid_t          tl_dst;
  logic [XLEN-1:0] tl_pc;
  logic [XLEN-1:0] tl_r2;
  logic [XLEN-1:0] tl_data;
  logic [XLEN-1:0] tl_mul;
  logic            tl_isequal;
  logic            tl_flag_mul;
  logic            tl_flag_reg;
  logic            tl_flag_jump;
  logic            tl_flag_branch;
  logic            tl_flag_iret;
  tlbwrite_t       tl_flag_tlbwrite;

  logic [N_THREADS-1:0]           pc_en;
  logic [XLEN-1:0]                pc_data;
  logic [N_THREADS-1:0][XLEN-1:0] rm0;
  logic [N_THREADS-1:0][XLEN-1:0] rm1;
  logic [N_THREADS-1:0][XLEN-1:0] rm2;
  logic [N_THREADS-1:0][XLEN-1:0] rm4;
  logic [N_THREADS-1:0]           regfile_wen;
  regid_t                         regfile_addr;
  logic [XLEN-1:0]                regfile_data;
  logic                           itlb_wen;
  logic                           dtlb_wen;
  logic [VPN_W-1:0]               itlb_vpn;
  logic [VPN_W-1:0]               dtlb_vpn;
  logic [PPN_W-1:0]               itlb_ppn;
  logic [PPN_W-1:0]               dtlb_ppn;
  logic                           exc_en;
  logic [T_W-1:0]                 exc_thread;
  logic [N_THREADS-1:0]           park_mask;

  modport master (
    output tl_thread, tl_isvalid, tl_itlb_miss, tl_dtlb_miss, tl_dst, tl_pc, tl_r2,
           tl_data, tl_mul, tl_isequal, tl_flag_mul, tl_flag_reg, tl_flag_jump,
           tl_flag_branch, tl_flag_iret, tl_flag_tlbwrite,
    input  pc_en, pc_data, rm0, rm1, rm2, rm4, regfile_wen, regfile_addr, regfile_data,
           itlb_wen, dtlb_wen, itlb_vpn, dtlb_vpn, itlb_ppn, dtlb_ppn,
           exc_en, exc_thread, park_mask
  );

  modport slave (
    input  tl_thread, tl_isvalid, tl_itlb_miss, tl_dtlb_miss, tl_dst, tl_pc, tl_r2,
           tl_data, tl_mul, tl_isequal, tl_flag_mul, tl_flag_reg, tl_flag_jump,
           tl_flag_branch, tl_flag_iret, tl_flag_tlbwrite,
    output pc_en, pc_data, rm0, rm1, rm2, rm4, regfile_wen, regfile_addr, regfile_data,
           itlb_wen, dtlb_wen, itlb_vpn, dtlb_vpn, itlb_ppn, dtlb_ppn,
           exc_en, exc_thread, park_mask
  );

endinterface

// File: rtl/stage_wb_mt_rr_pick.sv
// Round-robin picker: grants the first set mask bit strictly after 'last', wrapping.
module stage_wb_mt_rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned T_W = 2
) (
  input  logic [N-1:0]   mask,
  input  logic [T_W-1:0] last,
  output logic [N-1:0]   grant,
  output logic [T_W-1:0] idx
);

  logic           found;
  logic [T_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = T_W'((32'(last) + i) % N);
      if (!found && mask[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/stage_wb_mt.sv
// Multithreaded writeback/commit stage: in-order per-thread commit, exception lock,
// parking of faulting non-master threads and round-robin release after IRET.
module stage_wb_mt
  import stage_wb_mt_pkg::*;
#(
  parameter int unsigned     N_THREADS = 4,
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     VPN_W     = 20,
  parameter int unsigned     PPN_W     = 8,
  parameter logic [XLEN-1:0] BOOT_PC   = XLEN'(32'h1000),
  parameter logic [XLEN-1:0] EXC_PC    = XLEN'(32'h2000)
) (
  input logic          clk,
  input logic          rst,
  stage_wb_mt_if.slave wb
);

  localparam int unsigned T_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  typedef logic [N_THREADS-1:0][XLEN-1:0] bank_t;

  wb_state_t            state_q, state_d;
  logic [T_W-1:0]       master_q, master_d;
  logic [N_THREADS-1:0] park_q, park_d;
  bank_t                waiting_q, waiting_d;
  bank_t                rm0_q, rm0_d, rm1_q, rm1_d, rm2_q, rm2_d, rm4_q, rm4_d;
  logic [N_THREADS-1:0] pc_en_q, pc_en_d;
  logic [XLEN-1:0]      pc_data_q, pc_data_d;
  logic [N_THREADS-1:0] rf_wen_q, rf_wen_d;
  regid_t               rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]      rf_data_q, rf_data_d;
  logic                 itlb_wen_q, itlb_wen_d, dtlb_wen_q, dtlb_wen_d;
  logic [VPN_W-1:0]     itlb_vpn_q, itlb_vpn_d, dtlb_vpn_q, dtlb_vpn_d;
  logic [PPN_W-1:0]     itlb_ppn_q, itlb_ppn_d, dtlb_ppn_q, dtlb_ppn_d;
  logic                 exc_en_q, exc_en_d;
  logic [T_W-1:0]       exc_thread_q, exc_thread_d;

  logic [T_W-1:0]       tid;
  logic                 accept, exception, is_master, taken, bus_used;
  logic [N_THREADS-1:0] grant;
  logic [T_W-1:0]       pick_idx;

  stage_wb_mt_rr_pick #(.N(N_THREADS), .T_W(T_W)) u_rr_pick (
    .mask  (park_q),
    .last  (master_q),
    .grant (grant),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic; the pc bus is owned by accepted input before release.
  always_comb begin
    state_d      = state_q;
    master_d     = master_q;
    park_d       = park_q;
    waiting_d    = waiting_q;
    rm0_d        = rm0_q;
    rm1_d        = rm1_q;
    rm2_d        = rm2_q;
    rm4_d        = rm4_q;
    pc_en_d      = '0;
    pc_data_d    = pc_data_q;
    rf_wen_d     = '0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    itlb_wen_d   = 1'b0;
    dtlb_wen_d   = 1'b0;
    itlb_vpn_d   = itlb_vpn_q;
    itlb_ppn_d   = itlb_ppn_q;
    dtlb_vpn_d   = dtlb_vpn_q;
    dtlb_ppn_d   = dtlb_ppn_q;
    bus_used     = 1'b0;
    tid          = wb.tl_thread;
    exception    = wb.tl_itlb_miss | wb.tl_dtlb_miss;
    is_master    = (tid == master_q);
    accept       = (wb.tl_pc == waiting_q[tid]);
    taken        = wb.tl_flag_jump & (~wb.tl_flag_branch | wb.tl_isequal);

    if (accept) begin
      if (!wb.tl_isvalid) begin
        if (state_q == IDLE && exception) begin
          state_d        = HANDLER;
          master_d       = tid;
          pc_en_d[tid]   = 1'b1;
          pc_data_d      = EXC_PC;
          waiting_d[tid] = EXC_PC;
          rm0_d[tid]     = wb.tl_pc;
          rm4_d[tid]     = XLEN'(1);
          if (wb.tl_itlb_miss) begin
            rm1_d[tid] = wb.tl_pc;
            rm2_d[tid] = XLEN'(EXC_ITLB);
          end else begin
            rm1_d[tid] = wb.tl_data;
            rm2_d[tid] = XLEN'(EXC_DTLB);
          end
          bus_used = 1'b1;
        end else if (state_q != IDLE && exception && !is_master) begin
          park_d[tid] = 1'b1;
        end else begin
          pc_en_d[tid] = 1'b1;
          pc_data_d    = wb.tl_pc;
          bus_used     = 1'b1;
        end
      end else if (state_q != HANDLER || is_master) begin
        waiting_d[tid] = waiting_q[tid] + XLEN'(4);
        rf_wen_d[tid]  = wb.tl_flag_reg;
        rf_addr_d      = wb.tl_dst;
        rf_data_d      = wb.tl_flag_mul ? wb.tl_mul : wb.tl_data;
        case (wb.tl_flag_tlbwrite)
          TLBW_ITLB: begin
            itlb_wen_d = 1'b1;
            itlb_vpn_d = wb.tl_data[VPN_W-1:0];
            itlb_ppn_d = wb.tl_r2[PPN_W-1:0];
          end
          TLBW_DTLB: begin
            dtlb_wen_d = 1'b1;
            dtlb_vpn_d = wb.tl_data[VPN_W-1:0];
            dtlb_ppn_d = wb.tl_r2[PPN_W-1:0];
          end
          default: ;
        endcase
        if (taken) begin
          pc_en_d[tid] = 1'b1;
          bus_used     = 1'b1;
          if (wb.tl_flag_iret) begin
            pc_data_d      = rm0_q[tid];
            waiting_d[tid] = rm0_q[tid];
            rm4_d[tid]     = '0;
            state_d        = (park_q != '0) ? RELEASE : IDLE;
          end else begin
            pc_data_d      = wb.tl_data;
            waiting_d[tid] = wb.tl_data;
          end
        end
      end
    end

    if (state_q == RELEASE && !bus_used) begin
      if (park_q != '0) begin
        pc_en_d   = grant;
        pc_data_d = waiting_q[pick_idx];
      end
      park_d = park_d & ~grant;
      if (park_d == '0) state_d = IDLE;
    end

    exc_en_d     = (state_d == HANDLER);
    exc_thread_d = master_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      master_q     <= '0;
      park_q       <= '0;
      waiting_q    <= {N_THREADS{BOOT_PC}};
      rm0_q        <= '0;
      rm1_q        <= '0;
      rm2_q        <= '0;
      rm4_q        <= '0;
      pc_en_q      <= '0;
      pc_data_q    <= BOOT_PC;
      rf_wen_q     <= '0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      itlb_wen_q   <= 1'b0;
      dtlb_wen_q   <= 1'b0;
      itlb_vpn_q   <= '0;
      itlb_ppn_q   <= '0;
      dtlb_vpn_q   <= '0;
      dtlb_ppn_q   <= '0;
      exc_en_q     <= 1'b0;
      exc_thread_q <= '0;
    end else begin
      state_q      <= state_d;
      master_q     <= master_d;
      park_q       <= park_d;
      waiting_q    <= waiting_d;
      rm0_q        <= rm0_d;
      rm1_q        <= rm1_d;
      rm2_q        <= rm2_d;
      rm4_q        <= rm4_d;
      pc_en_q      <= pc_en_d;
      pc_data_q    <= pc_data_d;
      rf_wen_q     <= rf_wen_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      itlb_wen_q   <= itlb_wen_d;
      dtlb_wen_q   <= dtlb_wen_d;
      itlb_vpn_q   <= itlb_vpn_d;
      itlb_ppn_q   <= itlb_ppn_d;
      dtlb_vpn_q   <= dtlb_vpn_d;
      dtlb_ppn_q   <= dtlb_ppn_d;
      exc_en_q     <= exc_en_d;
      exc_thread_q <= exc_thread_d;
    end
  end

  assign wb.pc_en        = pc_en_q;
  assign wb.pc_data      = pc_data_q;
  assign wb.rm0          = rm0_q;
  assign wb.rm1          = rm1_q;
  assign wb.rm2          = rm2_q;
  assign wb.rm4          = rm4_q;
  assign wb.regfile_wen  = rf_wen_q;
  assign wb.regfile_addr = rf_addr_q;
  assign wb.regfile_data = rf_data_q;
  assign wb.itlb_wen     = itlb_wen_q;
  assign wb.dtlb_wen     = dtlb_wen_q;
  assign wb.itlb_vpn     = itlb_vpn_q;
  assign wb.itlb_ppn     = itlb_ppn_q;
  assign wb.dtlb_vpn     = dtlb_vpn_q;
  assign wb.dtlb_ppn     = dtlb_ppn_q;
  assign wb.exc_en       = exc_en_q;
  assign wb.exc_thread   = exc_thread_q;
  assign wb.park_mask    = park_q;

endmodule
